// File: rtl/block_xfer_pkg.sv
// Shared definitions for the block transfer family (FIFO, assembler, unpacker):
// default widths, a clog2 helper and the unpacker state encoding.
package block_xfer_pkg;

    localparam int DEF_WSIZE = 32;
    localparam int DEF_BSIZE = DEF_WSIZE * 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        UNPK_EMPTY      = 2'd0,
        UNPK_DRAIN      = 2'd1,
        UNPK_DRAIN_PEND = 2'd2
    } unpk_state_t;

endpackage

// File: rtl/block_to_word_unpacker_if.sv
// Block-in / word-out handshake bundle. The master drives blocks and consumes
// words; the slave modport is the unpacker's view.
interface block_to_word_unpacker_if
    import block_xfer_pkg::*;
#(
    parameter int WSIZE = DEF_WSIZE,
    parameter int BSIZE = DEF_BSIZE
);
    logic [BSIZE-1:0] block_in;
    logic             block_in_ready;
    logic             pull_block;
    logic [WSIZE-1:0] word_out;
    logic             word_ready;
    logic             word_out_hold;
    logic             last_word;

    modport master (
        output block_in, block_in_ready, word_out_hold,
        input  pull_block, word_out, word_ready, last_word
    );

    modport slave (
        input  block_in, block_in_ready, word_out_hold,
        output pull_block, word_out, word_ready, last_word
    );
endinterface

// File: rtl/block_word_mux.sv
// Combinational selector: picks word idx of a block, word 0 being the most
// significant slice.
module block_word_mux
    import block_xfer_pkg::*;
#(
    parameter int WSIZE  = DEF_WSIZE,
    parameter int NWORDS = 4,
    localparam int BSIZE = WSIZE * NWORDS,
    localparam int CNTW  = clog2(NWORDS)
) (
    input  logic [BSIZE-1:0] i_block,
    input  logic [CNTW-1:0]  i_idx,
    output logic [WSIZE-1:0] o_word
);

    // One-hot compare per word slot; exactly one slot matches any idx.
    always_comb begin
        o_word = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (i_idx == CNTW'(i)) begin
                o_word = i_block[BSIZE-1-i*WSIZE -: WSIZE];
            end else begin
                o_word = o_word;
            end
        end
    end

endmodule

// File: rtl/block_to_word_unpacker.sv
// Double-buffered block-to-word unpacker: an active block drains MS word first
// while a second block may wait in the pending register.
module block_to_word_unpacker
    import block_xfer_pkg::*;
#(
    parameter int WSIZE = DEF_WSIZE,
    parameter int BSIZE = WSIZE * 4
) (
    input  logic clock,
    input  logic reset,
    block_to_word_unpacker_if.slave bus
);

    localparam int NWORDS = BSIZE / WSIZE;
    localparam int CNTW   = clog2(NWORDS);

    unpk_state_t      r_state;
    logic [BSIZE-1:0] r_active;
    logic [BSIZE-1:0] r_pending;
    logic [CNTW-1:0]  r_idx;

    logic w_pull;
    logic w_word_ready;
    logic w_is_last;
    logic w_accept;
    logic w_xfer;

    // Handshake flags are pure state decodes so they never loop back through
    // the producer's or consumer's combinational logic.
    assign w_pull       = (r_state != UNPK_DRAIN_PEND);
    assign w_word_ready = (r_state != UNPK_EMPTY);
    assign w_is_last    = (r_idx == CNTW'(NWORDS - 1));
    assign w_accept     = bus.block_in_ready & w_pull;
    assign w_xfer       = w_word_ready & ~bus.word_out_hold;

    assign bus.pull_block = w_pull;
    assign bus.word_ready = w_word_ready;
    assign bus.last_word  = w_word_ready & w_is_last;

    block_word_mux #(
        .WSIZE  (WSIZE),
        .NWORDS (NWORDS)
    ) u_mux (
        .i_block (r_active),
        .i_idx   (r_idx),
        .o_word  (bus.word_out)
    );

    // Control FSM and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= UNPK_EMPTY;
            r_active  <= '0;
            r_pending <= '0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                UNPK_EMPTY: begin
                    if (w_accept) begin
                        r_active <= bus.block_in;
                        r_idx    <= '0;
                        r_state  <= UNPK_DRAIN;
                    end
                end
                UNPK_DRAIN: begin
                    if (w_xfer && w_is_last) begin
                        // Reloading on the last word keeps the stream bubble-free.
                        if (w_accept) begin
                            r_active <= bus.block_in;
                            r_idx    <= '0;
                        end else begin
                            r_state <= UNPK_EMPTY;
                        end
                    end else begin
                        if (w_xfer) begin
                            r_idx <= r_idx + CNTW'(1);
                        end
                        if (w_accept) begin
                            r_pending <= bus.block_in;
                            r_state   <= UNPK_DRAIN_PEND;
                        end
                    end
                end
                UNPK_DRAIN_PEND: begin
                    if (w_xfer) begin
                        if (w_is_last) begin
                            r_active <= r_pending;
                            r_idx    <= '0;
                            r_state  <= UNPK_DRAIN;
                        end else begin
                            r_idx <= r_idx + CNTW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= UNPK_EMPTY;
                    r_idx   <= '0;
                end
            endcase
        end
    end

endmodule
